// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed hex seven-segment scanner with dead time
// Optional leading-zero blanking is compiled in when SEVSEG_LZB_EN is defined.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 12000,
  parameter int DEAD           = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PLAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PDEAD   = PW'(DEAD);
  localparam logic [IW-1:0] IDXLAST = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_dp;

  logic [3:0]          nib;
  logic                dp_sel;
  logic [DIGITS-1:0]   an_l;
  logic [7:0]          seg_l;
  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;

  // logical active-high pattern, bit 0 = A ... bit 6 = G
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1100111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b1011000;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

`ifdef SEVSEG_LZB_EN
  // zfrom[i]: nibbles i..DIGITS-1 of the shadow are all zero
  logic [DIGITS-1:0] zfrom;
  always_comb begin
    zfrom = '0;
    zfrom[DIGITS-1] = (sh_val[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--)
      zfrom[i] = zfrom[i+1] & (sh_val[4*i +: 4] == 4'h0);
  end
`endif

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    an_l   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib     = sh_val[4*i +: 4];
        dp_sel  = sh_dp[i];
        an_l[i] = 1'b1;
      end
    end
    seg_l = {dp_sel, decode(nib)};
`ifdef SEVSEG_LZB_EN
    for (int i = 1; i < DIGITS; i++)
      if (idx == IW'(i) && zfrom[i]) seg_l[6:0] = 7'b0;
`endif
    if (pcnt < PDEAD || blank) begin
      seg_l = 8'h00;
      an_l  = '0;
    end
    seg_n = (SEG_ACTIVE_LOW != 0) ? ~seg_l : seg_l;
    an_n  = (AN_ACTIVE_LOW != 0) ? ~an_l : an_l;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt   <= '0;
      idx    <= '0;
      sh_val <= '0;
      sh_dp  <= '0;
      seg    <= SEG_OFF;
      an     <= AN_OFF;
    end else begin
      if (pcnt == PLAST) begin
        pcnt <= '0;
        idx  <= (idx == IDXLAST) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp;
      end
      seg <= seg_n;
      an  <= an_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan (model honours SEVSEG_LZB_EN)
module tb_seven_seg_scan;
  localparam int DIGITS = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD),
                   .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .blank(blank), .seg(seg), .an(an));

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
            7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
            7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001};
    return tbl[n];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: the display position is simply elapsed cycles since reset
  int         m_cnt;
  int         mp, md;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [6:0]  mg;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_val <= '0; m_dp <= '0; e_an <= '0; e_seg <= '0;
    end else begin
      mp = m_cnt % SCAN_DIV;
      md = (m_cnt / SCAN_DIV) % DIGITS;
      mg = dec(4'(m_val >> (4 * md)));
`ifdef SEVSEG_LZB_EN
      if (md > 0 && (m_val >> (4 * md)) == 16'h0) mg = 7'b0;
`endif
      if (mp >= DEAD && !blank) begin
        e_an  <= 4'(1 << md);
        e_seg <= {m_dp[md], mg};
      end else begin
        e_an  <= '0;
        e_seg <= '0;
      end
      m_cnt <= m_cnt + 1;
      if (load) begin
        m_val <= value;
        m_dp  <= dp;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("an_model", an, e_an);
      check("seg_model", seg, e_seg);
      check("an_onehot", 32'($countones(an) <= 1), 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] t, input string nm);
    int k = 0;
    while (an !== t && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(nm, an, t);
  endtask

  logic [6:0] abcd_exp [4];
  int k, d;

  initial begin
    abcd_exp = '{7'b1011110, 7'b1011000, 7'b1111100, 7'b1110111};
    @(negedge clk);
    check("reset_an", an, 4'b0000);
    check("reset_seg", seg, 8'h00);
    rst = 1'b0;

    // 1234 with DP on digit 0
    @(negedge clk);
    value = 16'h1234; dp = 4'b0001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_an(4'b0001, "first_d0");
    check("d0_seg", seg, 8'b1110_0110);
    k = 0;
    while (an == 4'b0001 && k < 20) begin k++; @(negedge clk); end
    check("d0_on_len", k, 6);
    k = 0;
    while (an == 4'b0000 && k < 20) begin k++; @(negedge clk); end
    check("gap_len", k, 2);
    check("d1_an", an, 4'b0010);
    tick(8); check("d2_an", an, 4'b0100);
    tick(8); check("d3_an", an, 4'b1000);
    check("d3_seg", seg, 8'b0000_0110);
    tick(8); check("d0_again", an, 4'b0001);

    // value changes without load must not show
    value = 16'hFFFF;
    tick(2); check("noload_seg", seg, 8'b1110_0110);
    load = 1'b1; dp = 4'b0000;
    tick(1); check("load_edge_old", seg, 8'b1110_0110);
    load = 1'b0;
    tick(1); check("load_new_f", seg, 8'b0111_0001);

    // blank mid-slot
    blank = 1'b1;
    tick(1);
    check("blank_an", an, 4'b0000);
    check("blank_seg", seg, 8'h00);
    tick(19);
    blank = 1'b0;
    tick(16);

    // async reset during digit 2 ON phase
    wait_an(4'b0100, "pre_rst_d2");
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", an, 4'b0000);
    check("async_rst_seg", seg, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("post_rst_an", an, (c >= 3 && c <= 8) ? 4'b0001 : 4'b0000);
    end

    // leading zeros
    value = 16'h0050; dp = 4'b0000; load = 1'b1;
    tick(1);
    load = 1'b0;
`ifdef SEVSEG_LZB_EN
    wait_an(4'b1000, "lz_d3_an"); check("lz_d3_seg", seg, 8'h00);
    wait_an(4'b0100, "lz_d2_an"); check("lz_d2_seg", seg, 8'h00);
`else
    wait_an(4'b1000, "lz_d3_an"); check("lz_d3_seg", seg, 8'b0011_1111);
    wait_an(4'b0100, "lz_d2_an"); check("lz_d2_seg", seg, 8'b0011_1111);
`endif
    wait_an(4'b0010, "lz_d1_an"); check("lz_d1_seg", seg, 8'b0110_1101);
    wait_an(4'b0001, "lz_d0_an"); check("lz_d0_seg", seg, 8'b0011_1111);

    // load coincident with slot wrap
    k = 0;
    while (m_cnt % SCAN_DIV != SCAN_DIV - 1 && k < 40) begin @(negedge clk); k++; end
    check("wrap_align", 32'(m_cnt % SCAN_DIV), 32'(SCAN_DIV - 1));
    d = ((m_cnt / SCAN_DIV) + 1) % DIGITS;
    value = 16'hABCD; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2);
    check("wrap_dead", an, 4'b0000);
    tick(1);
    check("wrap_an", an, 4'(1 << d));
    check("wrap_seg", seg, {1'b0, abcd_exp[d]});

    tick(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
